softmax_norm_ctrl: RTL and testbench
====================================

// Module: softmax_norm_ctrl
// PURPOSE
//   Sequencer for the last softmax step. Pass 1 reads LEN exp() values from the
//   intermediate memory and accumulates them into an FP32 sum using an internal
//   fadd7 adder.
//   Pass 2 re-reads the same values and streams them, with the held sum, to the
//   external FP32 divider stage (latency DIV_LAT).
//   It also produces the write-enable and address for the output memory, aligned
//   to the divider result.
// PARAMETERS
//   DW       32  data width, IEEE-754 single precision
//   AW       10  intermediate/output memory address width
//   ADD_LAT  7   fadd7 latency in cycles (clock/dataa/datab/result)
//   DIV_LAT  14  latency of the downstream divider
// PORTS
//   clk          in   1      clock, all logic on rising edge
//   rst          in   1      synchronous reset, active-low
//   start        in   1      one-cycle pulse; begins a job when idle
//   len          in   AW+1   element count, sampled on accepted start
//   busy         out  1      high from accepted start until done
//   done         out  1      one-cycle pulse at job end
//   mem_rd_addr  out  AW     intermediate memory read address
//   mem_rd_data  in   DW     read data, valid 1 cycle after mem_rd_addr
//   div_data     out  DW     dividend to divider (exp value)
//   div_sum      out  DW     divisor to divider (accumulated sum)
//   out_we       out  1      output memory write enable (divider result valid)
//   out_addr     out  AW     output memory write address
// BEHAVIOUR
// - Reset (rst=0 at edge): state IDLE; busy, done and out_we = 0.
//   mem_rd_addr, out_addr, div_data and div_sum = 0; sum register = 32'h0.
//   The valid/address delay line is cleared. Reset mid-job aborts with no further writes.
// - FSM: IDLE -> ACC_RD -> ACC_WAIT -> (ACC_RD | NORM) -> DRAIN -> DONE -> IDLE.
// - IDLE: start=1 latches len, clears sum to 0.0 and sets idx=0.
//   With len=0 it goes straight to DONE: no reads, no writes, sum stays 0.
//   Otherwise it goes to ACC_RD. start while busy is ignored.
// - ACC_RD (1 cycle): mem_rd_addr=idx.
// - ACC_WAIT (1+ADD_LAT cycles): fadd7 gets dataa=sum and datab=mem_rd_data on
//   the first cycle. The result is latched into sum on the last cycle.
//   Then: idx==len-1 goes to NORM with idx=0; otherwise idx++ and back to ACC_RD.
//   Pass 1 costs exactly len*(ADD_LAT+2) cycles; there is one add in flight at a time.
// - NORM (len cycles, k=0..len-1): mem_rd_addr=k on cycle k.
//   On cycle k+1, div_data=mem_rd_data for element k. div_sum holds sum for the whole pass.
//   A valid/address shift register of depth 1+DIV_LAT delays the reads.
//   The result is out_we=1 with out_addr=k exactly 1+DIV_LAT cycles after NORM cycle k.
//   out_we is otherwise 0.
// - DRAIN: wait until the delay line is empty (last out_we has fired).
// - DONE (1 cycle): done=1, busy=0 next cycle; return to IDLE.
// - busy=1 in every state except IDLE. out_addr wraps never, because len<=2^AW.
//   len>2^AW is clamped to 2^AW.
// - Divider NaN/inf/overflow flags are not observed; FP special values pass through unchanged.
// TESTING
// - len=4, mem={1.0,2.0,3.0,4.0} (3F800000,40000000,40400000,40800000):
//   sum=10.0 (41200000) after 36 cycles.
//   out_we pulses at addr 0..3 carry 0.1/0.2/0.3/0.4 (3DCCCCCD,3E4CCCCD,3E99999A,3ECCCCCD).
// - len=0 start -> done two cycles after start; busy high for one cycle;
//   no mem reads, no out_we.
// - len=1, mem={2.5} -> sum=2.5; single out_we at addr 0, exactly 1+DIV_LAT cycles
//   after the NORM read; result 1.0.
// - start pulsed again mid-pass-1 (len=4) -> ignored; sum and outputs identical to scenario 1.
// - rst=0 during NORM of a len=8 job -> next cycle out_we=0 and busy=0, no further writes.
//   A fresh len=2 job then completes correctly.
// - len=2^AW (1024) all 1.0 -> sum=1024.0 (44800000); 1024 writes,
//   out_addr 0..1023 in order, each 3A800000.

Source files
------------

// File: rtl/softmax_norm_ctrl.sv
// softmax_norm_ctrl: sequencer for the final softmax normalisation step.
//   Pass 1 reads len exp() values and accumulates them into an FP32 sum through
//   the internal fadd7 adder, with one add in flight at a time. Pass 2 re-reads
//   the values and streams them, together with the held sum, to an external FP32
//   divider of latency DIV_LAT. Output-memory write enable and address are
//   delayed so that they line up with the divider result.
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start, len        job request pulse and element count (clamped to 2^AW)
//   busy, done        job in progress / one-cycle completion pulse
//   mem_rd_addr       intermediate memory read address
//   mem_rd_data       read data, valid one cycle after mem_rd_addr
//   div_data, div_sum dividend / divisor presented to the divider
//   out_we, out_addr  output memory write strobe and address

// fadd7: FP32 adder, round-to-nearest-even, subnormals flushed to zero,
// NaN/inf propagated. Result appears LAT cycles after the operands.
// Ports: clock, dataa, datab in; result out.
module fadd7 #(
    parameter int LAT = 7
) (
    input  logic        clock,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);
    logic [31:0] pipe [LAT];

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  d;
        logic [49:0] sh;
        logic [26:0] mx;
        logic [26:0] my;
        logic [27:0] s;
        logic [24:0] mr;
        logic        rnd;
        int          e;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
            if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
            if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
            return (a[30:23] == 8'hFF) ? a : b;
        end
        if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'd0} : b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d = x[30:23] - y[30:23];
        if (d > 8'd31) d = 8'd31;
        // Align the smaller operand keeping guard/round bits plus a sticky bit.
        sh = {1'b1, y[22:0], 26'd0} >> d;
        my = {sh[49:24], |sh[23:0]};
        mx = {1'b1, x[22:0], 3'b000};
        e  = int'(x[30:23]);
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 1;
            end
        end else begin
            s = {1'b0, mx - my};
            if (s == 28'd0) return 32'h0000_0000;
            for (int unsigned i = 0; i < 26; i++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        if (e <= 0) return {x[31], 31'd0};
        rnd = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {x[31], 8'hFF, 23'd0};
        return {x[31], e[7:0], mr[22:0]};
    endfunction

    always_ff @(posedge clock) begin
        pipe[0] <= fp_add(dataa, datab);
        for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign result = pipe[LAT-1];
endmodule

module softmax_norm_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 10,
    parameter int ADD_LAT = 7,
    parameter int DIV_LAT = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic [DW-1:0] div_data,
    output logic [DW-1:0] div_sum,
    output logic          out_we,
    output logic [AW-1:0] out_addr
);
    localparam int          CW      = $clog2(ADD_LAT + 1);
    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ACC_RD, S_ACC_WAIT, S_NORM, S_DRAIN, S_DONE
    } state_t;

    state_t        state, next_state;
    logic [AW:0]   len_q, len_eff, idx;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] sum, add_result;
    logic [DIV_LAT:0] vld;
    logic [AW-1:0] addr_pipe [DIV_LAT+1];
    logic          busy_q, done_q;
    logic          idx_last, wait_last;

    assign len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    assign idx_last  = (idx == len_q - 1'b1);
    assign wait_last = (wait_cnt == CW'(ADD_LAT));

    // Operands are fed every cycle; only the sample taken on the first
    // ACC_WAIT cycle is consumed, ADD_LAT cycles later.
    fadd7 #(.LAT(ADD_LAT)) u_fadd (
        .clock  (clk),
        .dataa  (sum),
        .datab  (mem_rd_data),
        .result (add_result)
    );

    // State register; busy/done are registered so done lands one cycle after DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != S_IDLE);
            done_q <= (state == S_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = (len_eff == '0) ? S_DONE : S_ACC_RD;
            S_ACC_RD:   next_state = S_ACC_WAIT;
            S_ACC_WAIT: if (wait_last) next_state = idx_last ? S_NORM : S_ACC_RD;
            S_NORM:     if (idx_last) next_state = S_DRAIN;
            // The top stage is the write firing this cycle; nothing younger remains.
            S_DRAIN:    if (vld[DIV_LAT-1:0] == '0) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Datapath: length, index, add wait counter, sum and write delay line
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            sum      <= '0;
            vld      <= '0;
            for (int unsigned i = 0; i <= DIV_LAT; i++) addr_pipe[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= len_eff;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                S_ACC_RD: wait_cnt <= '0;
                S_ACC_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_last) begin
                        sum <= add_result;
                        idx <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                S_NORM:  idx <= idx + 1'b1;
                default: ;
            endcase
            vld          <= {vld[DIV_LAT-1:0], state == S_NORM};
            addr_pipe[0] <= idx[AW-1:0];
            for (int unsigned i = 1; i <= DIV_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    // Outputs
    always_comb begin
        mem_rd_addr = '0;
        if (state == S_ACC_RD || state == S_NORM) mem_rd_addr = idx[AW-1:0];
    end

    // vld[0] marks the cycle the NORM read data arrives from memory.
    assign div_data = vld[0] ? mem_rd_data : '0;
    assign div_sum  = sum;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out_we   = vld[DIV_LAT];
    assign out_addr = addr_pipe[DIV_LAT];
endmodule

// File: tb/tb_softmax_norm_ctrl.sv
module tb_softmax_norm_ctrl;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DIV_LAT = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy, done, out_we;
    logic [AW-1:0] mem_rd_addr, out_addr;
    logic [DW-1:0] mem_rd_data, div_data, div_sum;

    softmax_norm_ctrl #(.DW(DW), .AW(AW), .ADD_LAT(7), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .div_data(div_data),
        .div_sum(div_sum), .out_we(out_we), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [1024];
    always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc_at;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic [31:0] hist_d [32];
    logic [31:0] hist_s [32];

    function automatic real f32_to_real(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [23:0] m;
        int          e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        m = {1'b1, b[51:29]};
        if (b[28] && ((|b[27:0]) || m[0])) begin
            m = m + 24'd1;
            if (m == 24'd0) e = e + 1;
        end
        return {b[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] f32_div(input logic [31:0] a, input logic [31:0] b);
        if (b[30:23] == 8'd0) return 32'd0;
        return real_to_f32(f32_to_real(a) / f32_to_real(b));
    endfunction

    // Divider model (latency DIV_LAT) plus write scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] q;
        hist_d[cyc % 32] = div_data;
        hist_s[cyc % 32] = div_sum;
        if (out_we === 1'b1) begin
            we_count++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: got write addr=%0d at cycle %0d, required no write", out_addr, cyc);
            end else begin
                e = sbq.pop_front();
                q = f32_div(hist_d[(cyc - DIV_LAT) % 32], hist_s[(cyc - DIV_LAT) % 32]);
                if (out_addr !== e.addr || q !== e.data || cyc !== e.cyc_at) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             out_addr, q, cyc, e.addr, e.data, e.cyc_at);
                end
            end
        end
    end

    // Starts a job, pushes its expected writes, returns at the first negedge of the job.
    task automatic start_job(input int n, output int s_edge, output logic [31:0] exp_sum);
        logic [31:0] acc;
        exp_t        e;
        acc = 32'd0;
        for (int i = 0; i < n; i++) acc = real_to_f32(f32_to_real(acc) + f32_to_real(mem[i]));
        exp_sum = acc;
        @(negedge clk);
        start  = 1'b1;
        len    = (AW+1)'(n);
        s_edge = cyc + 1;
        for (int k = 0; k < n; k++) begin
            e.addr   = AW'(k);
            e.data   = f32_div(mem[k], acc);
            e.cyc_at = s_edge + 9 * n + k + 15;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n, input int s_edge,
                             input logic [31:0] exp_sum, input int we_before);
        int want;
        want = (n == 0) ? s_edge + 1 : s_edge + 10 * n + 16;
        for (int i = 0; i < 20 * n + 100 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || cyc !== want) begin
            errors++;
            $display("FAIL %s_done: got done=%b at cycle %0d, required done=1 at cycle %0d", name, done, cyc, want);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b, required 0", name, busy);
        end
        checks++;
        if (div_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s_sum: got %h, required %h", name, div_sum, exp_sum);
        end
        checks++;
        if (we_count - we_before !== n || sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes, %0d pending, required %0d writes, 0 pending",
                     name, we_count - we_before, sbq.size(), n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got %b, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, out_we} !== 3'b000 || mem_rd_addr !== '0 || out_addr !== '0 ||
            div_data !== '0 || div_sum !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b we=%b rd=%0d oa=%0d dd=%h ds=%h, required all 0",
                     busy, done, out_we, mem_rd_addr, out_addr, div_data, div_sum);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_four();
        mem[0] = 32'h3F80_0000;
        mem[1] = 32'h4000_0000;
        mem[2] = 32'h4040_0000;
        mem[3] = 32'h4080_0000;
    endtask

    task automatic test_basic();
        int s; logic [31:0] es; int wb;
        load_four();
        wb = we_count;
        start_job(4, s, es);
        checks++;
        if (es !== 32'h4120_0000 || sbq[0].data !== 32'h3DCC_CCCD || sbq[3].data !== 32'h3ECC_CCCD) begin
            errors++;
            $display("FAIL basic_model: got sum=%h q0=%h q3=%h, required 41200000 3dcccccd 3ecccccd",
                     es, sbq[0].data, sbq[3].data);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        while (cyc < s + 36) @(negedge clk);
        checks++;
        if (div_sum !== 32'h4120_0000) begin
            errors++;
            $display("FAIL basic_sum_36: got %h, required 41200000", div_sum);
        end
        wait_done("basic", 4, s, 32'h4120_0000, wb);
    endtask

    task automatic test_len_zero();
        int s; logic [31:0] es; int wb;
        wb = we_count;
        start_job(0, s, es);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy: got busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done("zero", 0, s, 32'h0, wb);
    endtask

    task automatic test_single();
        int s; logic [31:0] es; int wb;
        mem[0] = 32'h4020_0000;
        wb = we_count;
        start_job(1, s, es);
        checks++;
        if (sbq[0].data !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL single_model: got %h, required 3f800000", sbq[0].data);
        end
        wait_done("single", 1, s, 32'h4020_0000, wb);
    endtask

    task automatic test_start_ignored();
        int s; logic [31:0] es; int wb;
        load_four();
        wb = we_count;
        start_job(4, s, es);
        repeat (10) @(negedge clk);
        start = 1'b1;
        len   = 11'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", 4, s, 32'h4120_0000, wb);
    endtask

    task automatic test_reset_mid();
        int s; logic [31:0] es; int wb;
        for (int i = 0; i < 8; i++) mem[i] = real_to_f32(real'(i + 1));
        start_job(8, s, es);
        while (cyc < s + 72 + 3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        wb = we_count;
        checks++;
        if (busy !== 1'b0 || out_we !== 1'b0) begin
            errors++;
            $display("FAIL abort: got busy=%b we=%b, required 0 0", busy, out_we);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (we_count !== wb || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d writes busy=%b, required 0 writes busy=0", we_count - wb, busy);
        end
        mem[0] = 32'h4040_0000;
        mem[1] = 32'h3F80_0000;
        wb = we_count;
        start_job(2, s, es);
        checks++;
        if (sbq[0].data !== 32'h3F40_0000 || sbq[1].data !== 32'h3E80_0000) begin
            errors++;
            $display("FAIL after_abort_model: got %h %h, required 3f400000 3e800000", sbq[0].data, sbq[1].data);
        end
        wait_done("after_abort", 2, s, 32'h4080_0000, wb);
    endtask

    task automatic test_full();
        int s; logic [31:0] es; int wb;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h3F80_0000;
        wb = we_count;
        start_job(1024, s, es);
        checks++;
        if (sbq[1023].data !== 32'h3A80_0000) begin
            errors++;
            $display("FAIL full_model: got %h, required 3a800000", sbq[1023].data);
        end
        wait_done("full", 1024, s, 32'h4480_0000, wb);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_single();
        test_start_ignored();
        test_reset_mid();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
